// File: rtl/prescaler_bank_if.sv
// Bus bundle for prescaler_bank: channel controls, divide-value write port and enable outputs.
// The sync_restart signal exists only when PRESCALER_SYNC_EN is defined.
interface prescaler_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] oneshot;
  logic [NUM_CH-1:0] trigger;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_value;
  logic [NUM_CH-1:0] slowEnPulse;
  logic [NUM_CH-1:0] slowEnPulse_d;
  logic [NUM_CH-1:0] busy;
`ifdef PRESCALER_SYNC_EN
  logic              sync_restart;
`endif

  modport master (
`ifdef PRESCALER_SYNC_EN
    output sync_restart,
`endif
    output enable, oneshot, trigger, cfg_we, cfg_ch, cfg_value,
    input  slowEnPulse, slowEnPulse_d, busy
  );

  modport slave (
`ifdef PRESCALER_SYNC_EN
    input  sync_restart,
`endif
    input  enable, oneshot, trigger, cfg_we, cfg_ch, cfg_value,
    output slowEnPulse, slowEnPulse_d, busy
  );
endinterface

// File: rtl/prescaler_bank.sv
// Multi-channel clock-enable generator: periodic or one-shot divided pulses plus a delayed copy.
// Optional feature: define PRESCALER_SYNC_EN to add bus.sync_restart (global phase realignment).
module prescaler_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int DLY     = 1,
  parameter int RST_DIV = 49
) (
  input  logic             clk,
  input  logic             resetN,
  prescaler_bank_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} osState_t;

  logic [CNT_W-1:0]  cntR       [NUM_CH];
  logic [CNT_W-1:0]  divR       [NUM_CH];
  logic [CNT_W-1:0]  shadowR    [NUM_CH];
  logic [CNT_W-1:0]  shadowNext [NUM_CH];
  osState_t          stateR     [NUM_CH];
  logic [NUM_CH-1:0] modeR;
  logic [NUM_CH-1:0] pulseR;
  logic [NUM_CH-1:0] busyR;
  logic [NUM_CH-1:0] dlyR       [DLY];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] osMode;
  logic              syncRestart;

`ifdef PRESCALER_SYNC_EN
  assign syncRestart = bus.sync_restart;
`else
  assign syncRestart = 1'b0;
`endif

  // Per-channel shadow forwarding, wrap detect and effective mode (latched while a period is in progress)
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadowNext[i] = (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) ? bus.cfg_value : shadowR[i];
      wrap[i]       = (cntR[i] >= divR[i]);
      osMode[i]     = (modeR[i] ? (stateR[i] == RUN) : bus.enable[i]) ? modeR[i] : bus.oneshot[i];
    end
  end

  // Shadow divide registers written by the config port
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CH; i++) shadowR[i] <= CNT_W'(RST_DIV);
    end else begin
      for (int i = 0; i < NUM_CH; i++) shadowR[i] <= shadowNext[i];
    end
  end

  // Channel counters, one-shot FSMs and registered pulse/busy outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cntR[i]   <= '0;
        divR[i]   <= CNT_W'(RST_DIV);
        stateR[i] <= IDLE;
      end
      modeR  <= '0;
      pulseR <= '0;
      busyR  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (syncRestart) begin
          cntR[i]   <= '0;
          pulseR[i] <= 1'b0;
          stateR[i] <= IDLE;
          divR[i]   <= shadowNext[i];
          modeR[i]  <= bus.oneshot[i];
          busyR[i]  <= bus.enable[i] & ~bus.oneshot[i];
        end else if (!osMode[i]) begin
          stateR[i] <= IDLE;
          busyR[i]  <= bus.enable[i];
          if (bus.enable[i] && wrap[i]) begin
            cntR[i]   <= '0;
            pulseR[i] <= 1'b1;
            divR[i]   <= shadowNext[i];
            modeR[i]  <= bus.oneshot[i];
          end else if (bus.enable[i]) begin
            cntR[i]   <= cntR[i] + CNT_W'(1);
            pulseR[i] <= 1'b0;
          end else begin
            // Disabled: count frozen, but divide and mode may be updated freely
            pulseR[i] <= 1'b0;
            divR[i]   <= shadowNext[i];
            modeR[i]  <= bus.oneshot[i];
          end
        end else begin
          case (stateR[i])
            IDLE: begin
              cntR[i]   <= '0;
              pulseR[i] <= 1'b0;
              divR[i]   <= shadowNext[i];
              modeR[i]  <= bus.oneshot[i];
              if (bus.trigger[i] && bus.enable[i]) begin
                stateR[i] <= RUN;
                busyR[i]  <= 1'b1;
              end else begin
                stateR[i] <= IDLE;
                busyR[i]  <= 1'b0;
              end
            end
            RUN: begin
              if (bus.enable[i] && wrap[i]) begin
                cntR[i]   <= '0;
                pulseR[i] <= 1'b1;
                stateR[i] <= IDLE;
                busyR[i]  <= 1'b0;
                divR[i]   <= shadowNext[i];
                modeR[i]  <= bus.oneshot[i];
              end else if (bus.enable[i]) begin
                cntR[i]   <= cntR[i] + CNT_W'(1);
                pulseR[i] <= 1'b0;
                busyR[i]  <= 1'b1;
              end else begin
                pulseR[i] <= 1'b0;
                busyR[i]  <= 1'b1;
                divR[i]   <= shadowNext[i];
              end
            end
            default: begin
              cntR[i]   <= '0;
              pulseR[i] <= 1'b0;
              stateR[i] <= IDLE;
              busyR[i]  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Delay line producing slowEnPulse_d; keeps shifting regardless of enable
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < DLY; k++) dlyR[k] <= '0;
    end else begin
      dlyR[0] <= pulseR;
      for (int k = 1; k < DLY; k++) dlyR[k] <= dlyR[k-1];
    end
  end

  assign bus.slowEnPulse   = pulseR;
  assign bus.slowEnPulse_d = dlyR[DLY-1];
  assign bus.busy          = busyR;
endmodule
